product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the 16x16 gate-level multiplier. It accepts a stream of 32-bit unsigned products over a valid/ready handshake and sums each group (a run of products terminated by `in_last`) into a wide accumulator. It presents the group total, beat count and overflow flag on a held output handshake, then clears itself for the next group. The multiplier is purely combinational, so this block supplies the register boundary and flow control for the MAC datapath.

---
 rtl/product_accumulator_if.sv | 39 +++
 rtl/product_accumulator.sv | 109 ++++++++++
 tb/tb_product_accumulator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : product_accumulator_if                                       |
// | Description : Handshake bundle for the product accumulator. Carries the    |
// |               input beat stream (valid/ready/product/last), the group      |
// |               abort (clear) and the held result handshake.                 |
// |               master : the upstream producer / downstream consumer side    |
// |               slave  : the accumulator itself                              |
// | Ports       : in_valid, in_ready, in_product[31:0], in_last, clear,        |
// |               out_valid, out_ready, out_acc[ACC_W-1:0],                    |
// |               out_count[CNT_W-1:0], out_ovf                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface product_accumulator_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_product;
  logic             in_last;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_product, in_last, clear, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, clear, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : product_accumulator                                          |
// | Description : Group accumulator behind the 16x16 multiplier. Sums 32-bit   |
// |               unsigned products of a group (terminated by in_last) into an |
// |               ACC_W-bit accumulator, counts beats (saturating) and flags   |
// |               carry-out, then holds the result on out_valid/out_ready.     |
// | Macro       : PRODUCT_ACC_SAT_EN - when defined the accumulator clamps at  |
// |               2^ACC_W-1 on overflow; otherwise it wraps. ovf is set on     |
// |               carry-out in both builds.                                    |
// | Ports       : clk    - clock, rising edge                                  |
// |               rst_n  - asynchronous active-low reset                       |
// |               bus    - product_accumulator_if.slave handshake bundle       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module product_accumulator #(
  parameter int ACC_W = 40,  // 33..64
  parameter int CNT_W = 8    // 1..16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  product_accumulator_if.slave     bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;

  // in_ready is a function of state and clear only, never of in_valid.
  assign w_in_ready = (state_q == ACCUM) && !bus.clear;
  assign w_accept   = bus.in_valid && w_in_ready;
  // One extra bit so the carry-out is visible for the overflow flag.
  assign w_sum      = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, bus.in_product};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (bus.clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (w_accept) begin
`ifdef PRODUCT_ACC_SAT_EN
          // Once clamped, any non-zero product carries again, so the
          // accumulator stays at full scale for the rest of the group.
          acc_d = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
          acc_d = w_sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | w_sum[ACC_W];
          cnt_d = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // clear is deliberately ignored here so a presented result survives.
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_acc   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_product_accumulator                                       |
// | Description : Scoreboard bench. Two accumulators (40/8 and 33/2) receive   |
// |               identical stimulus; group results expected from plain wide   |
// |               arithmetic are queued and a monitor compares whatever the    |
// |               DUTs present. Honours PRODUCT_ACC_SAT_EN like the design.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_product_accumulator;

  typedef struct {
    logic [63:0] acc;
    logic [63:0] cnt;
    logic [63:0] ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(40), .CNT_W(8)) ifa ();
  product_accumulator_if #(.ACC_W(33), .CNT_W(2)) ifb ();

  product_accumulator #(.ACC_W(40), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  product_accumulator #(.ACC_W(33), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int total = 0;
  int bad   = 0;

  res_t qa[$];
  res_t qb[$];

  // Reference state: running exact sum and beat count of the open group,
  // plus whether a result is currently owed to the consumer.
  logic [127:0] gsum = '0;
  int           gn   = 0;
  bit           m_drain = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input int accw, input int cntw, input logic [127:0] s, input int n);
    res_t r;
    logic [127:0] lim;
    int cmax;
    lim  = 128'd1 << accw;
    cmax = (1 << cntw) - 1;
    r.ovf = (s >= lim) ? 64'd1 : 64'd0;
`ifdef PRODUCT_ACC_SAT_EN
    r.acc = (s >= lim) ? 64'(lim - 128'd1) : 64'(s);
`else
    r.acc = 64'(s % lim);
`endif
    r.cnt = (n > cmax) ? 64'(cmax) : 64'(n);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] p, input logic l, input logic c, input logic r);
    ifa.in_valid = v; ifa.in_product = p; ifa.in_last = l; ifa.clear = c; ifa.out_ready = r;
    ifb.in_valid = v; ifb.in_product = p; ifb.in_last = l; ifb.clear = c; ifb.out_ready = r;
  endtask

  // One clock of stimulus; handshake expectations come from the reference state.
  task automatic cycle(input logic v, input logic [31:0] p, input logic l, input logic c,
                       input logic r, output logic acc_o);
    logic exp_rdy;
    @(posedge clk); #1;
    drive(v, p, l, c, r);
    @(negedge clk);
    exp_rdy = !m_drain && !c;
    chk("in_ready_a", 64'(ifa.in_ready), 64'(exp_rdy));
    chk("in_ready_b", 64'(ifb.in_ready), 64'(exp_rdy));
    chk("out_valid_a", 64'(ifa.out_valid), 64'(m_drain));
    chk("out_valid_b", 64'(ifb.out_valid), 64'(m_drain));
    acc_o = v && exp_rdy;
    if (m_drain) begin
      if (r) m_drain = 1'b0;
    end else if (c) begin
      gsum = '0; gn = 0;
    end else if (acc_o) begin
      gsum = gsum + 128'(p);
      gn++;
      if (l) begin
        qa.push_back(model(40, 8, gsum, gn));
        qb.push_back(model(33, 2, gsum, gn));
        gsum = '0; gn = 0;
        m_drain = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [31:0] p, input logic l, input logic r);
    logic a;
    int k;
    k = 0;
    a = 1'b0;
    while (!a && k < 20) begin
      cycle(1'b1, p, l, 1'b0, r, a);
      k++;
    end
    if (!a) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input logic c, input logic r);
    logic a;
    cycle(1'b0, 32'd0, 1'b0, c, r, a);
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready_a", 64'(ifa.in_ready), 64'd1);
    chk("rst_in_ready_b", 64'(ifb.in_ready), 64'd1);
    chk("rst_out_valid_a", 64'(ifa.out_valid), 64'd0);
    chk("rst_out_acc_a", 64'(ifa.out_acc), 64'd0);
    chk("rst_out_acc_b", 64'(ifb.out_acc), 64'd0);
    chk("rst_out_cnt_a", 64'(ifa.out_count), 64'd0);
    qa.delete(); qb.delete();
    gsum = '0; gn = 0; m_drain = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every presented result must match the head of its queue;
  // the entry retires on the out_ready handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifa.out_valid) begin
          if (qa.size() == 0) chk("unexpected_a", 64'd1, 64'd0);
          else begin
            chk("acc_a", 64'(ifa.out_acc), qa[0].acc);
            chk("cnt_a", 64'(ifa.out_count), qa[0].cnt);
            chk("ovf_a", 64'(ifa.out_ovf), qa[0].ovf);
            if (ifa.out_ready) void'(qa.pop_front());
          end
        end
        if (ifb.out_valid) begin
          if (qb.size() == 0) chk("unexpected_b", 64'd1, 64'd0);
          else begin
            chk("acc_b", 64'(ifb.out_acc), qb[0].acc);
            chk("cnt_b", 64'(ifb.out_count), qb[0].cnt);
            chk("ovf_b", 64'(ifb.out_ovf), qb[0].ovf);
            if (ifb.out_ready) void'(qb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("reset_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("reset_out_acc", 64'(ifa.out_acc), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Basic group
    send(32'd6, 1'b0, 1'b1);
    send(32'd20, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    idle(1'b0, 1'b1);
    chk("basic_acc", 64'(ifa.out_acc), 64'h1_0000_0019);
    chk("basic_cnt", 64'(ifa.out_count), 64'd3);
    chk("basic_ovf", 64'(ifa.out_ovf), 64'd0);
    idle(1'b0, 1'b1);

    // Backpressure: stray in_valid pulses while the result is held
    send(32'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(i[0], $urandom, 1'b1, 1'b0, 1'b0, a);
    chk("bp_acc", 64'(ifa.out_acc), 64'h1234);
    idle(1'b0, 1'b1);
    send(32'd9, 1'b1, 1'b1);
    idle(1'b0, 1'b1);

    // Clear in ACCUM, then clear during DRAIN
    send(32'd100, 1'b0, 1'b1);
    send(32'd200, 1'b0, 1'b1);
    cycle(1'b1, 32'd7, 1'b0, 1'b1, 1'b1, a);
    send(32'd5, 1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("clear_acc", 64'(ifa.out_acc), 64'd5);
    chk("clear_cnt", 64'(ifa.out_count), 64'd1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    chk("drain_clear_acc", 64'(ifa.out_acc), 64'd5);
    idle(1'b0, 1'b1);

    // Overflow on the 33-bit instance
    for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, (i == 2), 1'b0);
    idle(1'b0, 1'b0);
`ifdef PRODUCT_ACC_SAT_EN
    chk("ovf_acc_b", 64'(ifb.out_acc), 64'h1_FFFF_FFFF);
`else
    chk("ovf_acc_b", 64'(ifb.out_acc), 64'h0_FFFF_FFFD);
`endif
    chk("ovf_flag_b", 64'(ifb.out_ovf), 64'd1);
    chk("ovf_acc_a", 64'(ifa.out_acc), 64'h2_FFFF_FFFD);
    chk("ovf_flag_a", 64'(ifa.out_ovf), 64'd0);
    idle(1'b0, 1'b1);

    // Count saturation on the 2-bit counter
    for (int i = 0; i < 6; i++) send(32'd1, (i == 5), 1'b0);
    idle(1'b0, 1'b0);
    chk("sat_cnt_b", 64'(ifb.out_count), 64'd3);
    chk("sat_acc_b", 64'(ifb.out_acc), 64'd6);
    chk("sat_cnt_a", 64'(ifa.out_count), 64'd6);
    idle(1'b0, 1'b1);

    // Async reset mid-group and mid-DRAIN
    send(32'd40, 1'b0, 1'b1);
    send(32'd41, 1'b0, 1'b1);
    async_reset();
    send(32'd3, 1'b1, 1'b1);
    idle(1'b0, 1'b1);
    send(32'd77, 1'b1, 1'b0);
    idle(1'b0, 1'b0);
    async_reset();
    send(32'd8, 1'b0, 1'b1);
    send(32'd2, 1'b1, 1'b1);
    idle(1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p;
      p = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle(($urandom_range(3) != 0), p, ($urandom_range(5) == 0),
            ($urandom_range(15) == 0), ($urandom_range(3) != 0), a);
    end

    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);
    chk("queue_empty_a", 64'(qa.size()), 64'd0);
    chk("queue_empty_b", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
